// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous ROM with 1-cycle read latency.
// Prefetches word-aligned addresses into a PC-tagged FIFO; a redirect flushes it and drops the in-flight read.
module rom_fetch_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   rom_en,
  output logic [31:0]            rom_addr,
  input  logic [31:0]            rom_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr_data,
  output logic [31:0]            instr_pc,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic [AW+1:0] occupancy_s;
  logic          issue_s;
  logic          pop_s;
  logic          write_s;

  // Space is reserved for the in-flight word, so a same-cycle pop never grants an extra issue.
  always_comb begin
    occupancy_s = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
    issue_s     = reset_n & ~redirect_valid & (occupancy_s < DEPTH_L);
    pop_s       = instr_valid & instr_ready;
    write_s     = inflight_q & ~redirect_valid;
  end

  assign rom_en      = issue_s;
  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count_q != {(AW+1){1'b0}}) & ~redirect_valid;
  assign instr_data  = data_q[head_q];
  assign instr_pc    = pc_q[head_q];
  assign fifo_count  = count_q;

  // Next-state: redirect overrides issue, capture and pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue_s;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      head_d     = tail_q;
      count_d    = {(AW+1){1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
      end else begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
      end
      if (write_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({write_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      head_q        <= {AW{1'b0}};
      tail_q        <= {AW{1'b0}};
      count_q       <= {(AW+1){1'b0}};
      data_q        <= '{default: 32'h0};
      pc_q          <= '{default: 32'h0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      if (write_s) begin
        data_q[tail_q] <= rom_data;
        pc_q[tail_q]   <= inflight_pc_q;
      end
    end
  end

endmodule
